// File: rtl/wb_arb_pkg.sv
// ----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types for the two-master Wishbone classic arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GNT_I, GNT_D)
//   master_t    : identifies a master (MST_I = instruction, MST_D = data)
// Optional feature macro: WB_ARB_ROUND_ROBIN_EN (used by wb_arb_pick and
// wb_arbiter; this package is the same in both builds).
// ----------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        MST_I = 1'b0,
        MST_D = 1'b1
    } master_t;

endpackage

// File: rtl/wb_arb_pick.sv
// ----------------------------------------------------------------------------
// wb_arb_pick
// Combinational arbitration policy. Chooses which master should be granted
// next, given which masters are competing for the bus.
// Ports:
//   i_req       : instruction master is competing
//   d_req       : data master is competing
//   last_grant  : master that held the most recent grant
//   next_master : master to grant (don't-care when neither requests)
// Optional feature macro: WB_ARB_ROUND_ROBIN_EN
//   defined   : on a tie, the master not last granted wins
//   undefined : fixed priority, D wins every tie; last_grant is ignored
// ----------------------------------------------------------------------------
module wb_arb_pick
    import wb_arb_pkg::*;
(
    input  logic    i_req,
    input  logic    d_req,
    input  master_t last_grant,
    output master_t next_master
);

`ifdef WB_ARB_ROUND_ROBIN_EN
    always_comb begin
        next_master = MST_D;
        if (i_req && d_req) begin
            next_master = (last_grant == MST_I) ? MST_D : MST_I;
        end else if (i_req) begin
            next_master = MST_I;
        end
    end
`else
    // The fixed-priority policy has no use for history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        next_master = MST_D;
        if (i_req && !d_req) begin
            next_master = MST_I;
        end
    end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// ----------------------------------------------------------------------------
// wb_arbiter
// Two-master (instruction I, data D) to one-slave Wishbone classic arbiter.
// A master keeps the grant for its whole CYC tenure; the granted master's
// signals are passed verbatim to the slave, the other master sees no ACK.
// Only the grant state is registered; all outputs are combinational.
// Ports:
//   clk, rst_n             : clock (rising edge), async active-low reset
//   I_* / D_*              : instruction / data master buses (ADR, SEL, WE,
//                            STB, CYC, DAT_W in; DAT_R, ACK out)
//   S_*                    : slave bus (ADR, SEL, WE, STB, CYC, DAT_W out;
//                            DAT_R, ACK in)
// Parameter: XLEN address/data width, SEL width XLEN/8.
// Optional feature macro: WB_ARB_ROUND_ROBIN_EN adds a last_grant register
// (reset to I) so that ties alternate instead of always favouring D.
// ----------------------------------------------------------------------------
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [XLEN-1:0]     I_ADR,
    input  logic [XLEN/8-1:0]   I_SEL,
    input  logic                I_WE,
    input  logic                I_STB,
    input  logic                I_CYC,
    input  logic [XLEN-1:0]     I_DAT_W,
    output logic [XLEN-1:0]     I_DAT_R,
    output logic                I_ACK,

    input  logic [XLEN-1:0]     D_ADR,
    input  logic [XLEN/8-1:0]   D_SEL,
    input  logic                D_WE,
    input  logic                D_STB,
    input  logic                D_CYC,
    input  logic [XLEN-1:0]     D_DAT_W,
    output logic [XLEN-1:0]     D_DAT_R,
    output logic                D_ACK,

    output logic [XLEN-1:0]     S_ADR,
    output logic [XLEN/8-1:0]   S_SEL,
    output logic                S_WE,
    output logic                S_STB,
    output logic                S_CYC,
    output logic [XLEN-1:0]     S_DAT_W,
    input  logic [XLEN-1:0]     S_DAT_R,
    input  logic                S_ACK
);

    arb_state_t state_q, state_d;
    master_t    last_grant;
    master_t    pick_master;
    arb_state_t pick_state;
    logic       pick_i_req;
    logic       pick_d_req;
    logic       any_req;
    logic       i_own;
    logic       d_own;

    // The current owner never competes: in GNT_x the FSM only consults the
    // picker after x has dropped CYC, so only the other master is a candidate.
    assign pick_i_req = I_CYC && (state_q != GNT_I);
    assign pick_d_req = D_CYC && (state_q != GNT_D);
    assign any_req    = pick_i_req || pick_d_req;
    assign pick_state = (pick_master == MST_D) ? GNT_D : GNT_I;

    wb_arb_pick u_pick (
        .i_req       (pick_i_req),
        .d_req       (pick_d_req),
        .last_grant  (last_grant),
        .next_master (pick_master)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = pick_state;
            end
            GNT_I: begin
                if (!I_CYC) state_d = any_req ? pick_state : IDLE;
            end
            GNT_D: begin
                if (!D_CYC) state_d = any_req ? pick_state : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

`ifdef WB_ARB_ROUND_ROBIN_EN
    master_t last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_d == GNT_I)      last_grant_d = MST_I;
        else if (state_d == GNT_D) last_grant_d = MST_D;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= MST_I;
        else        last_grant_q <= last_grant_d;
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = MST_I;
`endif

    // Ownership requires the owner's CYC to still be high, so the slave bus
    // drops to zero (and late ACKs are swallowed) in the cycle CYC falls.
    assign i_own = (state_q == GNT_I) && I_CYC;
    assign d_own = (state_q == GNT_D) && D_CYC;

    always_comb begin
        S_ADR   = '0;
        S_SEL   = '0;
        S_WE    = 1'b0;
        S_STB   = 1'b0;
        S_CYC   = 1'b0;
        S_DAT_W = '0;
        if (i_own) begin
            S_ADR   = I_ADR;
            S_SEL   = I_SEL;
            S_WE    = I_WE;
            S_STB   = I_STB;
            S_CYC   = I_CYC;
            S_DAT_W = I_DAT_W;
        end else if (d_own) begin
            S_ADR   = D_ADR;
            S_SEL   = D_SEL;
            S_WE    = D_WE;
            S_STB   = D_STB;
            S_CYC   = D_CYC;
            S_DAT_W = D_DAT_W;
        end
    end

    assign I_ACK   = i_own && S_ACK;
    assign D_ACK   = d_own && S_ACK;
    // Read data is broadcast; each master qualifies it with its own ACK.
    assign I_DAT_R = S_DAT_R;
    assign D_DAT_R = S_DAT_R;

endmodule

// File: tb/tb_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter: directed scenarios followed by a
// randomized run checked against a bus-ownership reference model.
// Honours WB_ARB_ROUND_ROBIN_EN in its reference model.
// ----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int XLEN = 32;
    localparam int SELW = XLEN / 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] I_ADR = '0, D_ADR = '0, I_DAT_W = '0, D_DAT_W = '0;
    logic [SELW-1:0] I_SEL = '0, D_SEL = '0;
    logic            I_WE = 1'b0, D_WE = 1'b0, I_STB = 1'b0, D_STB = 1'b0;
    logic            I_CYC = 1'b0, D_CYC = 1'b0;
    logic [XLEN-1:0] I_DAT_R, D_DAT_R;
    logic            I_ACK, D_ACK;
    logic [XLEN-1:0] S_ADR, S_DAT_W;
    logic [SELW-1:0] S_SEL;
    logic            S_WE, S_STB, S_CYC;
    logic [XLEN-1:0] S_DAT_R = '0;
    logic            S_ACK = 1'b0;

    int checks = 0;
    int failures = 0;

    wb_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .I_ADR(I_ADR), .I_SEL(I_SEL), .I_WE(I_WE), .I_STB(I_STB), .I_CYC(I_CYC),
        .I_DAT_W(I_DAT_W), .I_DAT_R(I_DAT_R), .I_ACK(I_ACK),
        .D_ADR(D_ADR), .D_SEL(D_SEL), .D_WE(D_WE), .D_STB(D_STB), .D_CYC(D_CYC),
        .D_DAT_W(D_DAT_W), .D_DAT_R(D_DAT_R), .D_ACK(D_ACK),
        .S_ADR(S_ADR), .S_SEL(S_SEL), .S_WE(S_WE), .S_STB(S_STB), .S_CYC(S_CYC),
        .S_DAT_W(S_DAT_W), .S_DAT_R(S_DAT_R), .S_ACK(S_ACK)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus (0 none, 1 I, 2 D). An owner keeps
    // the bus while its CYC is high; otherwise the bus goes to whoever else
    // is asking, with ties settled by the configured policy.
    int m_owner = 0;
    int m_last  = 1;
    int m_next;
    bit m_keep, m_ir, m_dr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= 0;
            m_last  <= 1;
        end else begin
            m_keep = (m_owner == 1 && I_CYC) || (m_owner == 2 && D_CYC);
            if (!m_keep) begin
                m_ir = I_CYC && (m_owner != 1);
                m_dr = D_CYC && (m_owner != 2);
`ifdef WB_ARB_ROUND_ROBIN_EN
                if (m_ir && m_dr) m_next = (m_last == 1) ? 2 : 1;
`else
                if (m_ir && m_dr) m_next = 2;
`endif
                else if (m_dr)    m_next = 2;
                else if (m_ir)    m_next = 1;
                else              m_next = 0;
                m_owner <= m_next;
                if (m_next != 0) m_last <= m_next;
            end
        end
    end

    // Advance to just after the next rising edge, where inputs are driven.
    task next_cycle();
        @(posedge clk);
        #1;
    endtask

    task go_idle();
        next_cycle();
        I_CYC = 0; I_STB = 0; I_WE = 0;
        D_CYC = 0; D_STB = 0; D_WE = 0;
        S_ACK = 0;
        repeat (2) next_cycle();
    endtask

    task test_reset();
        rst_n = 0;
        I_CYC = 1; I_STB = 1; I_ADR = 32'h0000_1000;
        D_CYC = 1; D_STB = 1; D_ADR = 32'h0000_2000;
        S_ACK = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (S_CYC !== 1'b0) begin failures++; $display("[TB] FAIL reset_s_cyc: got %0b expected 0", S_CYC); end
        checks++;
        if (S_STB !== 1'b0 || S_ADR !== '0) begin failures++; $display("[TB] FAIL reset_s_bus: got stb=%0b adr=%0h expected 0/0", S_STB, S_ADR); end
        checks++;
        if (I_ACK !== 1'b0 || D_ACK !== 1'b0) begin failures++; $display("[TB] FAIL reset_acks: got i=%0b d=%0b expected 0/0", I_ACK, D_ACK); end
        next_cycle();
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (S_CYC !== 1'b0) begin failures++; $display("[TB] FAIL reset_release_latency: got s_cyc=%0b expected 0", S_CYC); end
        @(negedge clk);
        checks++;
        if (S_CYC !== 1'b1 || S_ADR !== 32'h0000_2000) begin failures++; $display("[TB] FAIL reset_release_grant_d: got cyc=%0b adr=%0h expected 1/2000", S_CYC, S_ADR); end
        checks++;
        if (D_ACK !== 1'b1 || I_ACK !== 1'b0) begin failures++; $display("[TB] FAIL reset_release_acks: got i=%0b d=%0b expected 0/1", I_ACK, D_ACK); end
        // Abort the granted transfer with an asynchronous reset.
        #2 rst_n = 0;
        #1;
        checks++;
        if (S_CYC !== 1'b0 || D_ACK !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_transfer: got cyc=%0b d_ack=%0b expected 0/0", S_CYC, D_ACK); end
        next_cycle();
        rst_n = 1;
        go_idle();
    endtask

    task test_single_read();
        next_cycle();
        I_CYC = 1; I_STB = 1; I_WE = 0; I_ADR = 32'h0000_0100; I_SEL = '1;
        S_ACK = 0;
        @(negedge clk);
        checks++;
        if (S_STB !== 1'b0) begin failures++; $display("[TB] FAIL read_arb_latency: got s_stb=%0b expected 0", S_STB); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (S_STB !== 1'b1 || S_ADR !== 32'h0000_0100) begin failures++; $display("[TB] FAIL read_strobe: got stb=%0b adr=%0h expected 1/100", S_STB, S_ADR); end
        checks++;
        if (I_ACK !== 1'b0) begin failures++; $display("[TB] FAIL read_no_early_ack: got %0b expected 0", I_ACK); end
        next_cycle();
        S_ACK = 1; S_DAT_R = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (I_ACK !== 1'b1 || I_DAT_R !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL read_ack_data: got ack=%0b dat=%0h expected 1/deadbeef", I_ACK, I_DAT_R); end
        checks++;
        if (D_ACK !== 1'b0) begin failures++; $display("[TB] FAIL read_d_ack_quiet: got %0b expected 0", D_ACK); end
        go_idle();
    endtask

    task test_contention();
        next_cycle();
        I_CYC = 1; I_STB = 1; I_WE = 0; I_ADR = 32'h0000_0300;
        D_CYC = 1; D_STB = 1; D_WE = 1; D_ADR = 32'h0000_0400; D_DAT_W = 32'hCAFE_0001;
        S_ACK = 0;
        @(negedge clk);
        checks++;
        if (S_CYC !== 1'b0) begin failures++; $display("[TB] FAIL contention_latency: got s_cyc=%0b expected 0", S_CYC); end
        for (int beat = 0; beat < 3; beat++) begin
            next_cycle();
            S_ACK = 1;
            D_ADR = 32'h0000_0400 + 32'(beat * 4);
            @(negedge clk);
            checks++;
            if (D_ACK !== 1'b1 || I_ACK !== 1'b0) begin failures++; $display("[TB] FAIL contention_beat%0d_acks: got i=%0b d=%0b expected 0/1", beat, I_ACK, D_ACK); end
            checks++;
            if (S_ADR !== 32'h0000_0400 + 32'(beat * 4) || S_WE !== 1'b1) begin failures++; $display("[TB] FAIL contention_beat%0d_bus: got adr=%0h we=%0b expected %0h/1", beat, S_ADR, S_WE, 32'h400 + beat * 4); end
        end
        next_cycle();
        D_CYC = 0; D_STB = 0;
        @(negedge clk);
        checks++;
        if (S_CYC !== 1'b0 || D_ACK !== 1'b0 || I_ACK !== 1'b0) begin failures++; $display("[TB] FAIL contention_drop: got cyc=%0b i=%0b d=%0b expected 0/0/0", S_CYC, I_ACK, D_ACK); end
        next_cycle();
        S_ACK = 0;
        @(negedge clk);
        checks++;
        if (S_CYC !== 1'b1 || S_ADR !== 32'h0000_0300 || S_WE !== 1'b0) begin failures++; $display("[TB] FAIL contention_handover_i: got cyc=%0b adr=%0h we=%0b expected 1/300/0", S_CYC, S_ADR, S_WE); end
        go_idle();
    endtask

    task test_handover_gap();
        next_cycle();
        D_CYC = 1; D_STB = 1; D_WE = 0; D_ADR = 32'h0000_0500;
        next_cycle();
        @(negedge clk);
        checks++;
        if (S_CYC !== 1'b1) begin failures++; $display("[TB] FAIL gap_d_granted: got %0b expected 1", S_CYC); end
        next_cycle();
        D_CYC = 0; D_STB = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (S_CYC !== 1'b0) begin failures++; $display("[TB] FAIL gap_idle%0d: got s_cyc=%0b expected 0", k, S_CYC); end
            next_cycle();
        end
        I_CYC = 1; I_STB = 1; I_ADR = 32'h0000_0600;
        @(negedge clk);
        checks++;
        if (S_CYC !== 1'b0) begin failures++; $display("[TB] FAIL gap_i_latency: got s_cyc=%0b expected 0", S_CYC); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (S_CYC !== 1'b1 || S_ADR !== 32'h0000_0600) begin failures++; $display("[TB] FAIL gap_i_grant: got cyc=%0b adr=%0h expected 1/600", S_CYC, S_ADR); end
        go_idle();
    endtask

    task test_spurious_ack();
        next_cycle();
        S_ACK = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (I_ACK !== 1'b0 || D_ACK !== 1'b0 || S_CYC !== 1'b0) begin failures++; $display("[TB] FAIL spurious_ack%0d: got i=%0b d=%0b cyc=%0b expected 0/0/0", k, I_ACK, D_ACK, S_CYC); end
            next_cycle();
        end
        S_ACK = 0;
        go_idle();
    endtask

    task test_alternating_requests();
        int  grants[$];
        int  exp_seq[4];
        bit  i_acked, d_acked;
        exp_seq = '{2, 1, 2, 1};
        i_acked = 0;
        d_acked = 0;
        for (int n = 0; n < 30 && grants.size() < 4; n++) begin
            next_cycle();
            // Each master drops CYC for one cycle after an ACK, then re-requests.
            I_CYC = !i_acked; I_STB = I_CYC; I_WE = 0;
            D_CYC = !d_acked; D_STB = D_CYC; D_WE = 0;
            #1 S_ACK = S_STB;
            #1;
            i_acked = I_ACK;
            d_acked = D_ACK;
            if (D_ACK) grants.push_back(2);
            if (I_ACK) grants.push_back(1);
        end
        checks++;
        if (grants.size() < 4) begin
            failures++;
            $display("[TB] FAIL alternate_budget: got %0d grants expected 4", grants.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (grants[k] != exp_seq[k]) begin failures++; $display("[TB] FAIL alternate_grant%0d: got %0d expected %0d (1=I 2=D)", k, grants[k], exp_seq[k]); end
            end
        end
        go_idle();
    endtask

    task test_random();
        logic [70:0] exp_bus;
        logic        exp_i, exp_d;
        for (int n = 0; n < 600; n++) begin
            next_cycle();
            if ($urandom_range(0, 3) == 0) I_CYC = !I_CYC;
            if ($urandom_range(0, 3) == 0) D_CYC = !D_CYC;
            I_STB = I_CYC && ($urandom_range(0, 1) == 1);
            D_STB = D_CYC && ($urandom_range(0, 1) == 1);
            I_WE = ($urandom_range(0, 1) == 1);
            D_WE = ($urandom_range(0, 1) == 1);
            I_ADR = $urandom; D_ADR = $urandom;
            I_DAT_W = $urandom; D_DAT_W = $urandom;
            I_SEL = SELW'($urandom); D_SEL = SELW'($urandom);
            S_ACK = ($urandom_range(0, 1) == 1);
            S_DAT_R = $urandom;
            @(negedge clk);
            exp_i = (m_owner == 1) && I_CYC;
            exp_d = (m_owner == 2) && D_CYC;
            if (exp_i)      exp_bus = {I_CYC, I_STB, I_WE, I_SEL, I_ADR, I_DAT_W};
            else if (exp_d) exp_bus = {D_CYC, D_STB, D_WE, D_SEL, D_ADR, D_DAT_W};
            else            exp_bus = '0;
            checks++;
            if ({S_CYC, S_STB, S_WE, S_SEL, S_ADR, S_DAT_W} !== exp_bus) begin failures++; $display("[TB] FAIL random%0d_bus: got %h expected %h", n, {S_CYC, S_STB, S_WE, S_SEL, S_ADR, S_DAT_W}, exp_bus); end
            checks++;
            if (I_ACK !== (exp_i && S_ACK) || D_ACK !== (exp_d && S_ACK)) begin failures++; $display("[TB] FAIL random%0d_acks: got i=%0b d=%0b expected %0b/%0b", n, I_ACK, D_ACK, exp_i && S_ACK, exp_d && S_ACK); end
            checks++;
            if (I_DAT_R !== S_DAT_R || D_DAT_R !== S_DAT_R) begin failures++; $display("[TB] FAIL random%0d_dat_r: got %h/%h expected %h", n, I_DAT_R, D_DAT_R, S_DAT_R); end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_handover_gap();
        test_spurious_ack();
        test_alternating_requests();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master to one-slave Wishbone classic arbiter. Sits directly downstream of the core's instruction and data ports (flat signals), and upstream of the single unified memory/slave.
- Grants one master at a time for the whole CYC tenure and muxes that master onto the slave bus.
- Non-granted master is stalled: no ACK.

Parameters:
XLEN, 32, address/data width; SEL width is XLEN/8

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
I_ADR, D_ADR  input  XLEN  instr/data master address
I_SEL, D_SEL  input  XLEN/8  master byte selects
I_WE, D_WE  input  1  master write enable
I_STB, D_STB  input  1  master strobe
I_CYC, D_CYC  input  1  master cycle request
I_DAT_W, D_DAT_W  input  XLEN  master write data
I_DAT_R, D_DAT_R  output  XLEN  read data to masters
I_ACK, D_ACK  output  1  acknowledge to masters
S_ADR, S_SEL, S_WE, S_STB, S_CYC, S_DAT_W  output  XLEN/XLEN/8/1/1/1/XLEN  slave-side master signals
S_DAT_R  input  XLEN  slave read data
S_ACK  input  1  slave acknowledge

Behaviour:
- States: IDLE, GNT_I, GNT_D. State register only; all outputs combinational from state and inputs.
- Reset (rst_n low, async): state=IDLE immediately. S_CYC=S_STB=S_WE=0, S_ADR=S_SEL=S_DAT_W=0, I_ACK=D_ACK=0.
- IDLE: slave outputs held at 0. If any CYC is high, next state is the grant chosen by the arbitration rule. One cycle of arbitration latency: no slave STB in the cycle CYC first rises.
- Arbitration on simultaneous I_CYC and D_CYC:
  - Default: D wins (fixed priority).
  - Single requester always wins.
- GNT_x:
  - S_* = x's signals verbatim.
  - x_ACK = S_ACK; other master's ACK = 0.
  - I_DAT_R = D_DAT_R = S_DAT_R (broadcast; only valid with ACK).
- Grant is held while x_CYC=1, including across multiple STB/ACK beats and idle STB-low gaps within CYC.
- When x_CYC=0 in GNT_x:
  - Slave outputs drop to 0 that cycle.
  - Next state = other grant if the other CYC is high, else IDLE. No dead cycle beyond this one.
- S_ACK arriving in IDLE, or after CYC drop, is ignored: no master sees it.
- Reset asserted mid-transfer: grant abandoned, slave CYC falls asynchronously, no ACK forwarded. Slave must tolerate the aborted cycle.
- No timeout. A slave never ACKing hangs the granted master (intentional).

Optional Feature:
- Macro WB_ARB_ROUND_ROBIN_EN.
- Defined: adds a 1-bit last_grant register (reset value = I).
  - On a simultaneous request in IDLE, or on handover, the master not last granted wins.
  - last_grant updates on entry to each GNT state.
- Undefined: fixed D-over-I priority and no extra register.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, GNT_I, GNT_D}.
  - typedef enum logic master_t {MST_I, MST_D}.
- One sub-module, wb_arb_pick: combinational, inputs i_req, d_req and last_grant; outputs next master_t.
  - Isolates the priority/round-robin policy so the FSM is policy-agnostic.

Test Plan:
- Reset: hold rst_n=0 with I_CYC=D_CYC=1 -> S_CYC=0, both ACK=0. Release -> GNT_D after 1 cycle, S_ADR=D_ADR.
- Single instr read: I_CYC=I_STB=1, I_ADR=0x100, slave ACKs 2 cycles later with 0xDEADBEEF -> S_STB seen at cycle 1, I_ACK=1 with I_DAT_R=0xDEADBEEF, D_ACK stays 0.
- Contention: both CYC from the same cycle, D does 3-beat burst then drops CYC -> D holds grant for all 3 ACKs. Next cycle GNT_I, S_ADR=I_ADR.
- Handover gap: D drops CYC while I_CYC=0 -> IDLE with S_CYC=0. I_CYC rises 4 cycles later -> grant one cycle later.
- Spurious ACK: S_ACK=1 while IDLE -> I_ACK=D_ACK=0.
- With WB_ARB_ROUND_ROBIN_EN: both masters continuously re-request single beats -> grants alternate D,I,D,I (first D since last_grant resets to I).
